iq_noise_chan: RTL and testbench
================================

IQ_NOISE_CHAN -- requirements
Module: iq_noise_chan

Interface
REQ-001 Parameter NOISE_SHL, default 0, left-shift applied to the zero-mean noise sample (legal 0..3).
REQ-002 Parameter SEED_I, default 32'h0000_0001, I-channel LFSR reset value; a zero value SHALL be replaced by 32'h0000_0001.
REQ-003 Parameter SEED_Q, default 32'hACE1_2345, Q-channel LFSR reset value; the same zero-substitution rule as SEED_I applies.
REQ-004 CLK  input  1  single clock; all state SHALL be updated on the rising edge.
REQ-005 RST  input  1  asynchronous, active-low reset.
REQ-006 ce  input  1  global clock enable; when low, all state SHALL hold.
REQ-007 valid_i  input  1  ar/ai carry a sample this cycle.
REQ-008 ar, ai  input  11 each  signed two's-complement I/Q sample from the mapper.
REQ-009 noise_en  input  1  1 = add noise; 0 = add zero noise (the sample still passes through the pipeline).
REQ-010 xr, xi  output  11 each  signed noisy I/Q sample for the demapper.
REQ-011 valid_o  output  1  xr/xi are valid.
REQ-012 clip_cnt  output  16  count of saturated output components; saturates at 16'hFFFF.

Function
REQ-013 The block SHALL accept a sample on any cycle with ce=1 and valid_i=1; there is no backpressure.
REQ-014 Each channel SHALL hold a 32-bit Galois LFSR with polynomial x^32+x^22+x^2+x+1 (taps 32'h8020_0003).
- The LFSR SHALL advance one step per accepted sample, and only then.
REQ-015 The raw noise value SHALL be computed from the current (pre-advance) LFSR state S:
- sum of the four 6-bit unsigned slices S[5:0], S[11:6], S[17:12] and S[23:18];
- minus 126, giving a signed range of -126..126.
REQ-016 The noise SHALL be the raw value arithmetically left-shifted by NOISE_SHL (range ±1008), or 0 when noise_en=0.
REQ-017 Stage 1 (ce=1) SHALL register ar, ai, noise_i, noise_q, and valid_i.
REQ-018 Stage 2 (ce=1) SHALL compute the 12-bit signed sums a+noise, saturate them to [-1024, 1023], and register xr, xi, and valid_o.
REQ-019 Latency SHALL be exactly 2 ce-qualified cycles from valid_i to valid_o; throughput SHALL be one sample per ce cycle.
REQ-020 When ce=0, the pipeline, LFSRs, and clip_cnt SHALL hold; valid_o SHALL hold its last value.
REQ-021 The stage-1 payload for bubbles (valid_i=0) SHALL be don't-care; valid SHALL propagate as 0.
REQ-022 clip_cnt SHALL increment by the number of components (0, 1 or 2) saturated in stage 2 on cycles with ce=1 and a valid stage-1 entry.
- The count SHALL saturate at 16'hFFFF and never wrap.
REQ-023 Saturation SHALL occur only when the 12-bit sum is outside [-1024, 1023]; exact endpoint values SHALL NOT count as clips.

Reset
REQ-024 On RST=0 (asynchronous), the following SHALL take effect immediately regardless of ce:
- LFSR_I <= SEED_I, LFSR_Q <= SEED_Q;
- both stage valids <= 0, xr = xi = 0, clip_cnt = 0.
REQ-025 Reset mid-stream SHALL discard in-flight samples; no valid_o SHALL appear within the first 2 ce cycles after release.
REQ-026 Release of reset is assumed synchronous to CLK externally; the block adds no synchronizer.

Structure
REQ-027 The following SHALL live in a shared package (comm_pkg) for use by mapper, demapper, and this channel:
- the 11-bit sample width constant;
- the min/max sample constants (-1024, 1023);
- the LFSR tap constant.
REQ-028 One sub-module, lfsr32_galois, SHALL be instantiated twice (I and Q), with ports CLK, RST, ce, step, and state[31:0].

Verification
REQ-029 Passthrough: noise_en=0, ar=300, ai=-300 for one cycle -> two cycles later valid_o=1, xr=300, xi=-300, and clip_cnt=0.
REQ-030 Determinism: SEED_I=1, NOISE_SHL=0, noise_en=1, first sample after reset with ar=0 -> xr=-125 (slice sum 1 minus 126).
REQ-031 Saturation: NOISE_SHL=3, noise_en=1, 10,000 samples with ar=ai=1023 -> xr and xi are never >1023 or <-1024, and clip_cnt equals the model count.
REQ-032 ce gating: ce held low for 5 cycles with valid_i toggling -> outputs, LFSR states, and clip_cnt are unchanged; the stream resumes with the same sequence as a gap-free run.
REQ-033 Reset mid-operation: RST pulsed low while 2 samples are in flight -> valid_o drops immediately, clip_cnt=0, and the next sample reproduces the REQ-030 noise value.
REQ-034 Statistics: 65,536 samples with ar=ai=0 and NOISE_SHL=0 -> noise mean within ±2 and range within [-126, 126].

Source files
------------

// File: rtl/comm_pkg.sv
// Shared constants and helpers for the mapper, demapper and noise channel.
// Sample width, sample limits, LFSR taps, LFSR step and noise/saturation arithmetic.
package comm_pkg;

    localparam int SAMPLE_W = 11;
    localparam int SUM_W    = 12;

    typedef logic signed [SAMPLE_W-1:0] sample_t;
    typedef logic signed [SUM_W-1:0]    wide_t;

    localparam sample_t     SAMPLE_MIN = 11'sh400;
    localparam sample_t     SAMPLE_MAX = 11'sh3FF;
    localparam logic [31:0] LFSR_TAPS  = 32'h8020_0003;

    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? LFSR_TAPS : 32'h0);
    endfunction

    // Sum of four 6-bit slices recentred on zero: range -126..126.
    function automatic wide_t raw_noise(input logic [31:0] s);
        logic [SUM_W-1:0] acc;
        acc = {6'd0, s[5:0]} + {6'd0, s[11:6]} + {6'd0, s[17:12]} + {6'd0, s[23:18]};
        return wide_t'(acc - 12'd126);
    endfunction

    function automatic logic is_clipped(input wide_t v);
        return (v > wide_t'(SAMPLE_MAX)) || (v < wide_t'(SAMPLE_MIN));
    endfunction

    function automatic sample_t saturate(input wide_t v);
        if (v > wide_t'(SAMPLE_MAX))
            return SAMPLE_MAX;
        else if (v < wide_t'(SAMPLE_MIN))
            return SAMPLE_MIN;
        else
            return v[SAMPLE_W-1:0];
    endfunction

endpackage

// File: rtl/lfsr32_galois.sv
// 32-bit Galois LFSR that advances once per cycle where both ce and step are high.
// A zero seed would lock the register, so it is replaced by 1.
module lfsr32_galois
    import comm_pkg::*;
#(
    parameter logic [31:0] SEED = 32'h0000_0001
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        ce,
    input  logic        step,
    output logic [31:0] state
);

    localparam logic [31:0] SEED_EFF = (SEED == 32'h0) ? 32'h0000_0001 : SEED;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST)
            state <= SEED_EFF;
        else if (ce && step)
            state <= lfsr_next(state);
    end

endmodule

// File: rtl/iq_noise_chan.sv
// Two-stage I/Q noise channel: adds LFSR-derived zero-mean noise to each sample,
// saturates to the 11-bit sample range and counts saturated components.
module iq_noise_chan
    import comm_pkg::*;
#(
    parameter int          NOISE_SHL = 0,
    parameter logic [31:0] SEED_I    = 32'h0000_0001,
    parameter logic [31:0] SEED_Q    = 32'hACE1_2345
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       ce,
    input  logic                       valid_i,
    input  logic signed [SAMPLE_W-1:0] ar,
    input  logic signed [SAMPLE_W-1:0] ai,
    input  logic                       noise_en,
    output logic signed [SAMPLE_W-1:0] xr,
    output logic signed [SAMPLE_W-1:0] xi,
    output logic                       valid_o,
    output logic [15:0]                clip_cnt
);

    logic [31:0] lfsr_i;
    logic [31:0] lfsr_q;
    logic        accept;

    assign accept = ce && valid_i;

    lfsr32_galois #(.SEED(SEED_I)) u_lfsr_i (
        .CLK(CLK), .RST(RST), .ce(ce), .step(valid_i), .state(lfsr_i)
    );

    lfsr32_galois #(.SEED(SEED_Q)) u_lfsr_q (
        .CLK(CLK), .RST(RST), .ce(ce), .step(valid_i), .state(lfsr_q)
    );

    wide_t noise_i_c;
    wide_t noise_q_c;

    // Noise is taken from the pre-advance state so the first sample uses the seed.
    always_comb begin
        noise_i_c = '0;
        noise_q_c = '0;
        if (noise_en && accept) begin
            noise_i_c = raw_noise(lfsr_i) <<< NOISE_SHL;
            noise_q_c = raw_noise(lfsr_q) <<< NOISE_SHL;
        end
    end

    logic    s1_valid;
    sample_t s1_ar;
    sample_t s1_ai;
    wide_t   s1_ni;
    wide_t   s1_nq;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            s1_valid <= 1'b0;
            s1_ar    <= '0;
            s1_ai    <= '0;
            s1_ni    <= '0;
            s1_nq    <= '0;
        end else if (ce) begin
            s1_valid <= valid_i;
            s1_ar    <= ar;
            s1_ai    <= ai;
            s1_ni    <= noise_i_c;
            s1_nq    <= noise_q_c;
        end
    end

    wide_t       sum_r;
    wide_t       sum_i;
    logic        clip_r;
    logic        clip_i;
    logic [16:0] cnt_next;

    always_comb begin
        sum_r    = wide_t'(s1_ar) + s1_ni;
        sum_i    = wide_t'(s1_ai) + s1_nq;
        clip_r   = is_clipped(sum_r);
        clip_i   = is_clipped(sum_i);
        cnt_next = {1'b0, clip_cnt} + {16'd0, clip_r} + {16'd0, clip_i};
    end

    // The clip counter sticks at all-ones instead of wrapping.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            valid_o  <= 1'b0;
            xr       <= '0;
            xi       <= '0;
            clip_cnt <= '0;
        end else if (ce) begin
            valid_o <= s1_valid;
            xr      <= saturate(sum_r);
            xi      <= saturate(sum_i);
            if (s1_valid)
                clip_cnt <= cnt_next[16] ? 16'hFFFF : cnt_next[15:0];
        end
    end

endmodule

// File: tb/tb_iq_noise_chan.sv
// Randomized self-checking bench for iq_noise_chan (NOISE_SHL=0 and NOISE_SHL=3 instances).
// Expected outputs come from a sample-level model: LFSR sequence, slice-sum noise, clamp.
module tb_iq_noise_chan;

    logic               CLK = 1'b0;
    logic               RST = 1'b0;
    logic               ce = 1'b0;
    logic               valid_i = 1'b0;
    logic               noise_en = 1'b0;
    logic signed [10:0] ar = '0;
    logic signed [10:0] ai = '0;
    logic signed [10:0] xr0, xi0, xr3, xi3;
    logic               vo0, vo3;
    logic [15:0]        cc0, cc3;

    int n_checks = 0;
    int n_err    = 0;

    always #5 CLK = ~CLK;

    iq_noise_chan #(.NOISE_SHL(0)) dut (
        .CLK(CLK), .RST(RST), .ce(ce), .valid_i(valid_i), .ar(ar), .ai(ai),
        .noise_en(noise_en), .xr(xr0), .xi(xi0), .valid_o(vo0), .clip_cnt(cc0)
    );

    iq_noise_chan #(.NOISE_SHL(3)) dut3 (
        .CLK(CLK), .RST(RST), .ce(ce), .valid_i(valid_i), .ar(ar), .ai(ai),
        .noise_en(noise_en), .xr(xr3), .xi(xi3), .valid_o(vo3), .clip_cnt(cc3)
    );

    typedef struct {
        bit v;
        int r0, i0, r3, i3;
        int c0, c3;
    } ent_t;

    ent_t        pend[$];
    logic [31:0] m_lfsr_i, m_lfsr_q;
    bit          exp_v;
    int          exp_r0, exp_i0, exp_r3, exp_i3;
    int          exp_c0, exp_c3;

    function automatic int noise_of(logic [31:0] s, int shl, bit en);
        int raw;
        raw = int'(s[5:0]) + int'(s[11:6]) + int'(s[17:12]) + int'(s[23:18]) - 126;
        return en ? raw * (1 << shl) : 0;
    endfunction

    function automatic int clamp(int v);
        return (v > 1023) ? 1023 : (v < -1024) ? -1024 : v;
    endfunction

    function automatic int clipped(int v);
        return (v > 1023 || v < -1024) ? 1 : 0;
    endfunction

    function automatic logic [31:0] step_lfsr(logic [31:0] s);
        return (s >> 1) ^ (s[0] ? 32'h8020_0003 : 32'h0);
    endfunction

    task automatic model_reset();
        pend.delete();
        m_lfsr_i = 32'h0000_0001;
        m_lfsr_q = 32'hACE1_2345;
        exp_v  = 1'b0;
        exp_r0 = 0; exp_i0 = 0; exp_r3 = 0; exp_i3 = 0;
        exp_c0 = 0; exp_c3 = 0;
    endtask

    task automatic tick(bit v, int a_r, int a_i, bit nen, bit c);
        ent_t e, o;
        ce = c; valid_i = v; ar = a_r[10:0]; ai = a_i[10:0]; noise_en = nen;
        @(posedge CLK);
        #1;
        if (c) begin
            e = '{default: 0};
            e.v = v;
            if (v) begin
                e.r0 = clamp(a_r + noise_of(m_lfsr_i, 0, nen));
                e.i0 = clamp(a_i + noise_of(m_lfsr_q, 0, nen));
                e.r3 = clamp(a_r + noise_of(m_lfsr_i, 3, nen));
                e.i3 = clamp(a_i + noise_of(m_lfsr_q, 3, nen));
                e.c0 = clipped(a_r + noise_of(m_lfsr_i, 0, nen)) + clipped(a_i + noise_of(m_lfsr_q, 0, nen));
                e.c3 = clipped(a_r + noise_of(m_lfsr_i, 3, nen)) + clipped(a_i + noise_of(m_lfsr_q, 3, nen));
                m_lfsr_i = step_lfsr(m_lfsr_i);
                m_lfsr_q = step_lfsr(m_lfsr_q);
            end
            pend.push_back(e);
            if (pend.size() == 2) begin
                o = pend.pop_front();
                exp_v = o.v;
                if (o.v) begin
                    exp_r0 = o.r0; exp_i0 = o.i0; exp_r3 = o.r3; exp_i3 = o.i3;
                    exp_c0 = (exp_c0 + o.c0 > 65535) ? 65535 : exp_c0 + o.c0;
                    exp_c3 = (exp_c3 + o.c3 > 65535) ? 65535 : exp_c3 + o.c3;
                end
            end else begin
                exp_v = 1'b0;
            end
        end
    endtask

    task automatic do_reset();
        RST = 1'b0;
        #1;
        model_reset();
        @(posedge CLK);
        #1;
        RST = 1'b1;
    endtask

    task automatic test_reset();
        ce = 1'b1; valid_i = 1'b1; ar = 11'sd100; ai = 11'sd100;
        RST = 1'b0;
        model_reset();
        repeat (2) @(posedge CLK);
        #1;
        n_checks++;
        if (vo0 !== 1'b0 || xr0 !== 11'sd0 || xi0 !== 11'sd0 || cc0 !== 16'd0) begin
            n_err++;
            $display("[TB] FAIL reset_dut0 vo=%0b xr=%0d xi=%0d cnt=%0d required all zero", vo0, xr0, xi0, cc0);
        end
        n_checks++;
        if (vo3 !== 1'b0 || xr3 !== 11'sd0 || xi3 !== 11'sd0 || cc3 !== 16'd0) begin
            n_err++;
            $display("[TB] FAIL reset_dut3 vo=%0b xr=%0d xi=%0d cnt=%0d required all zero", vo3, xr3, xi3, cc3);
        end
        RST = 1'b1;
    endtask

    task automatic test_passthrough();
        do_reset();
        tick(1, 300, -300, 0, 1);
        n_checks++;
        if (vo0 !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL pass_latency1 valid_o=%0b required 0", vo0);
        end
        tick(0, 0, 0, 0, 1);
        n_checks++;
        if (vo0 !== 1'b1 || xr0 !== 11'sd300 || xi0 !== -11'sd300 || cc0 !== 16'd0) begin
            n_err++;
            $display("[TB] FAIL passthrough vo=%0b xr=%0d xi=%0d cnt=%0d required 1 300 -300 0", vo0, xr0, xi0, cc0);
        end
        n_checks++;
        if (vo3 !== 1'b1 || xr3 !== 11'sd300 || xi3 !== -11'sd300 || cc3 !== 16'd0) begin
            n_err++;
            $display("[TB] FAIL passthrough_shl3 vo=%0b xr=%0d xi=%0d cnt=%0d required 1 300 -300 0", vo3, xr3, xi3, cc3);
        end
    endtask

    task automatic test_determinism();
        do_reset();
        tick(1, 0, 0, 1, 1);
        tick(0, 0, 0, 1, 1);
        n_checks++;
        if (vo0 !== 1'b1 || xr0 !== -11'sd125) begin
            n_err++;
            $display("[TB] FAIL determinism vo=%0b xr=%0d required 1 -125", vo0, xr0);
        end
        n_checks++;
        if (xr3 !== -11'sd1000) begin
            n_err++;
            $display("[TB] FAIL determinism_shl3 xr=%0d required -1000", xr3);
        end
        n_checks++;
        if (int'(xi0) !== exp_i0 || int'(xi3) !== exp_i3) begin
            n_err++;
            $display("[TB] FAIL determinism_q xi0=%0d xi3=%0d required %0d %0d", xi0, xi3, exp_i0, exp_i3);
        end
    endtask

    task automatic test_random();
        int a_r, a_i;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            case ($urandom_range(0, 5))
                0:       begin a_r = 1023;  a_i = -1024; end
                1:       begin a_r = -1024; a_i = 1023;  end
                default: begin a_r = int'($urandom_range(0, 2047)) - 1024; a_i = int'($urandom_range(0, 2047)) - 1024; end
            endcase
            tick($urandom_range(0, 3) != 0, a_r, a_i, $urandom_range(0, 1) == 1, $urandom_range(0, 4) != 0);
            n_checks++;
            if (vo0 !== exp_v || int'(cc0) !== exp_c0 || (exp_v && (int'(xr0) !== exp_r0 || int'(xi0) !== exp_i0))) begin
                n_err++;
                $display("[TB] FAIL random_dut0 n=%0d vo=%0b xr=%0d xi=%0d cnt=%0d required %0b %0d %0d %0d",
                         n, vo0, xr0, xi0, cc0, exp_v, exp_r0, exp_i0, exp_c0);
            end
            n_checks++;
            if (vo3 !== exp_v || int'(cc3) !== exp_c3 || (exp_v && (int'(xr3) !== exp_r3 || int'(xi3) !== exp_i3))) begin
                n_err++;
                $display("[TB] FAIL random_dut3 n=%0d vo=%0b xr=%0d xi=%0d cnt=%0d required %0b %0d %0d %0d",
                         n, vo3, xr3, xi3, cc3, exp_v, exp_r3, exp_i3, exp_c3);
            end
        end
    endtask

    task automatic test_ce_gating();
        do_reset();
        for (int n = 0; n < 30; n++) begin
            if (n >= 10 && n < 15) tick(n % 2 == 0, 1023, -1024, 1, 0);
            else tick(1, 900, -900, 1, 1);
            n_checks++;
            if (vo3 !== exp_v || int'(cc3) !== exp_c3 || (exp_v && (int'(xr3) !== exp_r3 || int'(xi3) !== exp_i3))) begin
                n_err++;
                $display("[TB] FAIL ce_gating n=%0d vo=%0b xr=%0d xi=%0d cnt=%0d required %0b %0d %0d %0d",
                         n, vo3, xr3, xi3, cc3, exp_v, exp_r3, exp_i3, exp_c3);
            end
        end
    endtask

    task automatic test_saturation();
        int a;
        do_reset();
        for (int n = 0; n < 10002; n++) begin
            a = (n < 5000) ? 1023 : -1024;
            tick(n < 10000, a, a, 1, 1);
            n_checks++;
            if (vo3 !== exp_v || int'(cc3) !== exp_c3 || (exp_v && (int'(xr3) !== exp_r3 || int'(xi3) !== exp_i3))) begin
                n_err++;
                $display("[TB] FAIL saturation n=%0d vo=%0b xr=%0d xi=%0d cnt=%0d required %0b %0d %0d %0d",
                         n, vo3, xr3, xi3, cc3, exp_v, exp_r3, exp_i3, exp_c3);
            end
        end
        n_checks++;
        if (int'(cc0) !== exp_c0 || exp_c3 == 0) begin
            n_err++;
            $display("[TB] FAIL sat_count cnt0=%0d required %0d (model shl3 count %0d)", cc0, exp_c0, exp_c3);
        end
    endtask

    task automatic test_reset_midstream();
        for (int n = 0; n < 3; n++) tick(1, 1023, 1023, 1, 1);
        n_checks++;
        if (vo3 !== 1'b1 || int'(cc3) !== exp_c3) begin
            n_err++;
            $display("[TB] FAIL pre_reset vo=%0b cnt=%0d required 1 %0d", vo3, cc3, exp_c3);
        end
        #2;
        RST = 1'b0;
        #1;
        n_checks++;
        if (vo3 !== 1'b0 || cc3 !== 16'd0 || vo0 !== 1'b0 || cc0 !== 16'd0) begin
            n_err++;
            $display("[TB] FAIL midstream_reset vo=%0b %0b cnt=%0d %0d required 0 0 0 0", vo0, vo3, cc0, cc3);
        end
        model_reset();
        @(posedge CLK);
        #1;
        RST = 1'b1;
        tick(1, 0, 0, 1, 1);
        n_checks++;
        if (vo0 !== 1'b0 || vo3 !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL stale_after_reset vo=%0b %0b required 0 0", vo0, vo3);
        end
        tick(0, 0, 0, 1, 1);
        n_checks++;
        if (vo0 !== 1'b1 || xr0 !== -11'sd125) begin
            n_err++;
            $display("[TB] FAIL reset_reseed vo=%0b xr=%0d required 1 -125", vo0, xr0);
        end
    endtask

    task automatic test_statistics();
        longint sum;
        int     mn, mx;
        sum = 0; mn = 1000; mx = -1000;
        do_reset();
        for (int n = 0; n < 65538; n++) begin
            tick(n < 65536, 0, 0, 1, 1);
            if (vo0 === 1'b1) begin
                sum += longint'(xr0);
                if (int'(xr0) < mn) mn = int'(xr0);
                if (int'(xr0) > mx) mx = int'(xr0);
            end
            n_checks++;
            if (vo0 !== exp_v || (exp_v && (int'(xr0) !== exp_r0 || int'(xi0) !== exp_i0))) begin
                n_err++;
                $display("[TB] FAIL stats_stream n=%0d vo=%0b xr=%0d xi=%0d required %0b %0d %0d",
                         n, vo0, xr0, xi0, exp_v, exp_r0, exp_i0);
            end
        end
        n_checks++;
        if (sum > 131072 || sum < -131072) begin
            n_err++;
            $display("[TB] FAIL noise_mean sum=%0d required |sum|<=131072", sum);
        end
        n_checks++;
        if (mn < -126 || mx > 126 || mn > mx) begin
            n_err++;
            $display("[TB] FAIL noise_range min=%0d max=%0d required within -126..126", mn, mx);
        end
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_determinism();
        test_random();
        test_ce_gating();
        test_saturation();
        test_reset_midstream();
        test_statistics();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
